// File: rtl/cp0_trap_seq_if.sv
// Pipeline-side and CP0-port signals of the trap sequencer, bundled so the
// sequencer (slave) and its environment (master) connect through one port.
interface cp0_trap_seq_if;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [5:0]  irq;
  logic        eret;
  logic        cp0_w;
  logic [4:0]  a1;
  logic [31:0] wd;
  logic [31:0] rd1;
  logic        exc_ack;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        in_handler;

  modport master (
    output exc_req, exc_code, exc_pc, irq, eret, rd1,
    input  cp0_w, a1, wd, exc_ack, stall, pc_redirect, pc_target, in_handler
  );

  modport slave (
    input  exc_req, exc_code, exc_pc, irq, eret, rd1,
    output cp0_w, a1, wd, exc_ack, stall, pc_redirect, pc_target, in_handler
  );
endinterface

// File: rtl/cp0_trap_seq.sv
// Exception/interrupt sequencer: on entry it saves EPC, Cause and Status
// (with EXL set) through CP0's single port and redirects to the handler;
// on eret it reads EPC back, clears EXL and redirects to the saved PC.
module cp0_trap_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
  parameter logic [4:0]  STATUS_REG   = 5'd12,
  parameter logic [4:0]  CAUSE_REG    = 5'd13,
  parameter logic [4:0]  EPC_REG      = 5'd14
) (
  input  logic           clk,
  input  logic           reset,
  cp0_trap_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_STATUS,
    REDIR,
    E_RD_EPC,
    E_W_STATUS,
    E_REDIR
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] epc_q;
  logic [4:0]  code_q;
  logic [5:0]  ip_q;
  logic [31:0] status_q;
  logic        in_handler_q;
  logic        int_pend;
  logic        accept_entry;
  logic        accept_eret;

  // In IDLE the port addresses Status, so rd1 carries IE/EXL/IM here.
  assign int_pend = (|(bus.irq & bus.rd1[15:10])) & bus.rd1[0] & ~bus.rd1[1];

  assign bus.in_handler = in_handler_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and CP0/PC control decode; accepts are held off during reset.
  always_comb begin
    next_state      = state;
    bus.cp0_w       = 1'b0;
    bus.a1          = STATUS_REG;
    bus.wd          = 32'h0;
    bus.exc_ack     = 1'b0;
    bus.stall       = 1'b1;
    bus.pc_redirect = 1'b0;
    bus.pc_target   = 32'h0;
    accept_entry    = 1'b0;
    accept_eret     = 1'b0;
    case (state)
      IDLE: begin
        bus.stall = 1'b0;
        if (!reset) begin
          if (bus.exc_req) begin
            accept_entry = 1'b1;
            bus.exc_ack  = 1'b1;
            bus.stall    = 1'b1;
            next_state   = W_EPC;
          end else if (int_pend) begin
            accept_entry = 1'b1;
            bus.stall    = 1'b1;
            next_state   = W_EPC;
          end else if (bus.eret) begin
            accept_eret = 1'b1;
            bus.stall   = 1'b1;
            next_state  = E_RD_EPC;
          end
        end
      end
      W_EPC: begin
        bus.cp0_w  = 1'b1;
        bus.a1     = EPC_REG;
        bus.wd     = epc_q;
        next_state = W_CAUSE;
      end
      W_CAUSE: begin
        bus.cp0_w  = 1'b1;
        bus.a1     = CAUSE_REG;
        bus.wd     = {16'b0, ip_q, 3'b0, code_q, 2'b0};
        next_state = W_STATUS;
      end
      W_STATUS: begin
        bus.cp0_w  = 1'b1;
        bus.a1     = STATUS_REG;
        bus.wd     = status_q | 32'h2;
        next_state = REDIR;
      end
      REDIR: begin
        bus.pc_redirect = 1'b1;
        bus.pc_target   = HANDLER_ADDR;
        next_state      = IDLE;
      end
      E_RD_EPC: begin
        bus.a1     = EPC_REG;
        next_state = E_W_STATUS;
      end
      E_W_STATUS: begin
        bus.cp0_w  = 1'b1;
        bus.a1     = STATUS_REG;
        bus.wd     = status_q & ~32'h2;
        next_state = E_REDIR;
      end
      E_REDIR: begin
        bus.pc_redirect = 1'b1;
        bus.pc_target   = epc_q;
        next_state      = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the trap context at accept, EPC during eret, and track EXL.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q        <= 32'h0;
      code_q       <= 5'h0;
      ip_q         <= 6'h0;
      status_q     <= 32'h0;
      in_handler_q <= 1'b0;
    end else begin
      if (accept_entry) begin
        epc_q    <= bus.exc_pc;
        code_q   <= bus.exc_req ? bus.exc_code : 5'h0;
        ip_q     <= bus.irq;
        status_q <= bus.rd1;
      end else if (accept_eret) begin
        status_q <= bus.rd1;
      end
      if (state == E_RD_EPC) begin
        epc_q <= bus.rd1;
      end
      if (state == W_STATUS) begin
        in_handler_q <= 1'b1;
      end else if (state == E_W_STATUS) begin
        in_handler_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_trap_seq.sv
// Scoreboard bench for cp0_trap_seq: a CP0 register-file model answers the
// read port, stimulus pushes expected (cycle, write/redirect/ack) events and
// a negedge monitor pops and compares every event the DUT presents.
module tb_cp0_trap_seq;

  localparam int K_WRITE = 0;
  localparam int K_REDIR = 1;
  localparam int K_ACK   = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] regs[32];
  logic        pre_en;
  logic [4:0]  pre_a;
  logic [31:0] pre_d;

  cp0_trap_seq_if bus();

  cp0_trap_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter; stimulus and monitor both refer to the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // CP0 register file model with combinational read and a preset port.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      if (bus.cp0_w === 1'b1) regs[bus.a1] <= bus.wd;
      if (pre_en) regs[pre_a] <= pre_d;
    end
  end

  assign bus.rd1 = regs[bus.a1];

  task automatic scoreEvent(input int kind, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event cyc=%0d got kind=%0d a=%0d d=%h, required none",
               cyc, kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a !== a || e.d !== d) begin
        errors++;
        $display("[TB] FAIL event got kind=%0d cyc=%0d a=%0d d=%h, required kind=%0d cyc=%0d a=%0d d=%h",
                 kind, cyc, a, d, e.kind, e.cyc, e.a, e.d);
      end
    end
  endtask

  // Monitor: compare every ack, CP0 write and redirect against the queue.
  always @(negedge clk) begin
    if (bus.exc_ack === 1'b1) scoreEvent(K_ACK, 5'd0, 32'h0);
    if (bus.cp0_w === 1'b1) scoreEvent(K_WRITE, bus.a1, bus.wd);
    if (bus.pc_redirect === 1'b1) scoreEvent(K_REDIR, 5'd0, bus.pc_target);
  end

  task automatic expectEvent(input int kind, input int c, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic expectEntry(input int t, input bit ack, input logic [31:0] epc,
                             input logic [31:0] cause, input logic [31:0] status);
    if (ack) expectEvent(K_ACK, t, 5'd0, 32'h0);
    expectEvent(K_WRITE, t + 1, 5'd14, epc);
    expectEvent(K_WRITE, t + 2, 5'd13, cause);
    expectEvent(K_WRITE, t + 3, 5'd12, status);
    expectEvent(K_REDIR, t + 4, 5'd0, 32'h0000_0080);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s got %h, required %h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [4:0] code, input logic [31:0] pc,
                               input logic [5:0] lines, input logic er);
    bus.exc_req  = req;
    bus.exc_code = code;
    bus.exc_pc   = pc;
    bus.irq      = lines;
    bus.eret     = er;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic presetReg(input logic [4:0] a, input logic [31:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_en = 1'b1;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cp0_w"}, bus.cp0_w, 32'h0);
    checkOutput({tag, "_exc_ack"}, bus.exc_ack, 32'h0);
    checkOutput({tag, "_stall"}, bus.stall, 32'h0);
    checkOutput({tag, "_pc_redirect"}, bus.pc_redirect, 32'h0);
    checkOutput({tag, "_in_handler"}, bus.in_handler, 32'h0);
    checkOutput({tag, "_pc_target"}, bus.pc_target, 32'h0);
    checkOutput({tag, "_wd"}, bus.wd, 32'h0);
    checkOutput({tag, "_a1"}, bus.a1, 32'd12);
  endtask

  // Directed stimulus sequence.
  initial begin
    int t;
    reset  = 1'b1;
    pre_en = 1'b0;
    pre_a  = 5'd0;
    pre_d  = 32'h0;
    applyStimulus(1'b0, 5'd0, 32'h0, 6'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;

    // Synchronous exception.
    presetReg(5'd12, 32'h0000_0401);
    t = cyc;
    applyStimulus(1'b1, 5'd4, 32'h0040_0010, 6'd0, 1'b0);
    expectEntry(t, 1'b1, 32'h0040_0010, 32'h0000_0010, 32'h0000_0403);
    waitUntil(t + 1);
    bus.exc_req = 1'b0;
    @(negedge clk);
    checkOutput("exc_stall_busy", bus.stall, 32'h1);
    waitUntil(t + 5);
    @(negedge clk);
    checkOutput("exc_in_handler", bus.in_handler, 32'h1);
    checkOutput("exc_idle_stall", bus.stall, 32'h0);

    // Eret back to the saved EPC.
    presetReg(5'd14, 32'h0040_0014);
    t = cyc;
    applyStimulus(1'b0, 5'd0, 32'h0, 6'd0, 1'b1);
    expectEvent(K_WRITE, t + 2, 5'd12, 32'h0000_0401);
    expectEvent(K_REDIR, t + 3, 5'd0, 32'h0040_0014);
    waitUntil(t + 1);
    bus.eret = 1'b0;
    @(negedge clk);
    checkOutput("eret_rd_epc_a1", bus.a1, 32'd14);
    waitUntil(t + 4);
    @(negedge clk);
    checkOutput("eret_in_handler", bus.in_handler, 32'h0);

    // Hardware interrupt, then held irq with EXL=1 must not re-enter.
    presetReg(5'd12, 32'h0000_0401);
    t = cyc;
    applyStimulus(1'b0, 5'd0, 32'h0040_0020, 6'b000001, 1'b0);
    expectEntry(t, 1'b0, 32'h0040_0020, 32'h0000_0400, 32'h0000_0403);
    waitUntil(t + 9);
    @(negedge clk);
    checkOutput("irq_held_stall", bus.stall, 32'h0);
    checkOutput("irq_in_handler", bus.in_handler, 32'h1);
    bus.irq = 6'd0;

    // Masked by IM, then masked by IE=0.
    presetReg(5'd12, 32'h0000_0401);
    bus.irq = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mask_im_stall", bus.stall, 32'h0);
    end
    @(posedge clk);
    #1;
    bus.irq = 6'd0;
    presetReg(5'd12, 32'h0000_0400);
    bus.irq = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mask_ie_stall", bus.stall, 32'h0);
    end
    @(posedge clk);
    #1;
    bus.irq = 6'd0;

    // Exception and eret together: exception wins, eret is dropped.
    presetReg(5'd12, 32'h0000_0401);
    t = cyc;
    applyStimulus(1'b1, 5'd10, 32'h0040_0030, 6'd0, 1'b1);
    expectEntry(t, 1'b1, 32'h0040_0030, 32'h0000_0028, 32'h0000_0403);
    waitUntil(t + 1);
    bus.exc_req = 1'b0;
    bus.eret    = 1'b0;
    waitUntil(t + 6);
    @(negedge clk);
    checkOutput("simul_in_handler", bus.in_handler, 32'h1);

    // Reset while in W_CAUSE: no Status write and no redirect follow.
    presetReg(5'd12, 32'h0000_0401);
    t = cyc;
    applyStimulus(1'b1, 5'd4, 32'h0040_0040, 6'd0, 1'b0);
    expectEvent(K_ACK, t, 5'd0, 32'h0);
    expectEvent(K_WRITE, t + 1, 5'd14, 32'h0040_0040);
    expectEvent(K_WRITE, t + 2, 5'd13, 32'h0000_0010);
    waitUntil(t + 1);
    bus.exc_req = 1'b0;
    waitUntil(t + 2);
    reset = 1'b1;
    waitUntil(t + 3);
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("midreset");
    waitUntil(t + 9);
    @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cp0_trap_seq.md
# cp0_trap_seq

Exception/interrupt sequencer that drives the CP0 register file from the pipeline side. It accepts synchronous exceptions, masked hardware interrupts and `eret`, and issues the CP0 read/write cycles needed to enter and leave a handler: save EPC, Cause and Status, then restore Status. It sits between the core's control path and CP0's single read/write port, and it stalls the pipeline and redirects the PC while a sequence is in progress.

## Interface
- `HANDLER_ADDR`, 32'h0000_0080: PC target on exception/interrupt entry.
- `STATUS_REG`, 12: CP0 index of Status (bit0 IE, bit1 EXL, bits15:10 IM).
- `CAUSE_REG`, 13: CP0 index of Cause (bits6:2 ExcCode, bits15:10 IP, other bits 0).
- `EPC_REG`, 14: CP0 index of EPC.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `exc_req` in 1: pipeline exception request, held until `exc_ack`.
- `exc_code` in 5: ExcCode of the request (interrupts use 0).
- `exc_pc` in 32: PC to save in EPC (faulting PC, or next PC for an interrupt).
- `irq` in 6: hardware interrupt lines, level.
- `eret` in 1: one-cycle pulse, an `eret` instruction in execute.
- `cp0_w` out 1: CP0 write enable.
- `a1` out 5: CP0 register index (read and write).
- `wd` out 32: CP0 write data.
- `rd1` in 32: CP0 combinational read data for `a1`.
- `exc_ack` out 1: one-cycle accept pulse for `exc_req`.
- `stall` out 1: freeze the pipeline.
- `pc_redirect` out 1: one-cycle pulse; the PC loads `pc_target`.
- `pc_target` out 32: redirect address.
- `in_handler` out 1: registered copy of the EXL bit written by this block.

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, REDIR, E_RD_EPC, E_W_STATUS, E_REDIR.
- In IDLE: `a1`=STATUS_REG and `cp0_w`=0.
  - `int_pend` = |(irq & rd1[15:10]) & rd1[0] & ~rd1[1].
- Priority in IDLE: `exc_req` > `int_pend` > `eret`.
  - An `eret` coincident with either of the others is discarded.
- Entry accept (IDLE, event taken):
  - Latch epc_q=`exc_pc`, code_q (`exc_code`, or 0 for an interrupt), ip_q=`irq`, status_q=`rd1`.
  - Pulse `exc_ack` only for `exc_req`.
  - Go to W_EPC.
- W_EPC: `cp0_w`=1, `a1`=EPC_REG, `wd`=epc_q; then W_CAUSE.
- W_CAUSE: `cp0_w`=1, `a1`=CAUSE_REG, `wd`={16'b0, ip_q, 3'b0, code_q, 2'b0}; then W_STATUS.
- W_STATUS: `cp0_w`=1, `a1`=STATUS_REG, `wd`=status_q|32'h2; `in_handler`<=1; then REDIR.
- REDIR: `pc_redirect`=1, `pc_target`=HANDLER_ADDR; then IDLE.
- Eret accept (IDLE): latch status_q=`rd1`; go to E_RD_EPC.
- E_RD_EPC: `a1`=EPC_REG, epc_q<=`rd1`; then E_W_STATUS.
- E_W_STATUS: `cp0_w`=1, `a1`=STATUS_REG, `wd`=status_q & ~32'h2; `in_handler`<=0; then E_REDIR.
- E_REDIR: `pc_redirect`=1, `pc_target`=epc_q; then IDLE.
- `eret` with EXL already 0 runs the same sequence; Status is rewritten unchanged.
- `irq` changes after accept are ignored; IP comes from ip_q.

## Timing
- Reset values:
  - State IDLE.
  - `cp0_w`, `exc_ack`, `stall`, `pc_redirect` and `in_handler` are 0.
  - `pc_target`, `wd`, epc_q, code_q, ip_q and status_q are 0.
  - `a1`=STATUS_REG.
- Reset in any state returns to IDLE at the next edge. No further CP0 write and no redirect are issued.
- `stall`=1 in the accept cycle and in every non-IDLE state; 0 in IDLE otherwise.
- Entry accepted at cycle T:
  - CP0 writes commit at the end of T+1 (EPC), T+2 (Cause) and T+3 (Status).
  - `pc_redirect` is high in T+4.
  - IDLE again at T+5, where a new event can be accepted.
- Eret accepted at cycle T: EPC is read in T+1, the Status write commits at the end of T+2, and `pc_redirect` is high in T+3.
- The pipeline drops `exc_req` in the cycle after `exc_ack`. A request still high in IDLE is treated as a new exception.
- At most one CP0 write per cycle. `a1`, `wd`, `cp0_w`, `pc_target` and `pc_redirect` are decoded combinationally from state and latches.

## Test plan
- Exception with Status=32'h0000_0401, `exc_req`=1, code=5'd4, pc=32'h0040_0010:
  - `exc_ack` at T.
  - Writes EPC=32'h0040_0010, Cause=32'h0000_0010, Status=32'h0000_0403.
  - Redirect to 32'h80 at T+4.
- Interrupt with Status=32'h0000_0401 and `irq`=6'b000001:
  - Entry with Cause=32'h0000_0400.
  - No `exc_ack`.
  - With EXL=1 afterwards, holding `irq` high gives no re-entry.
- Masking: `irq`=6'b000010 with IM=6'b000001, or with IE=0, gives no entry. `stall` stays 0.
- Eret with EPC=32'h0040_0014 and Status=32'h0000_0403:
  - Status write 32'h0000_0401 at the end of T+2.
  - `pc_redirect` with target 32'h0040_0014 at T+3.
  - `in_handler` falls to 0.
- Simultaneous `exc_req` and `eret` in IDLE: the exception sequence runs and `eret` is discarded (no E_* states).
- Reset asserted in W_CAUSE: no Status write, no `pc_redirect`, all outputs at their reset values the next cycle.
